// File: rtl/s2mm_axi_writer_if.sv
// s2mm_axi_writer_if: command, AXI4-Stream input, AXI4 write channels and status of the S2MM engine
interface s2mm_axi_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int CNT_W = 24
);
  logic cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CNT_W-1:0] cmd_beats;
  logic s_tvalid, s_tready, s_tlast;
  logic [DATA_W-1:0] s_tdata;
  logic m_awvalid, m_awready;
  logic [ADDR_W-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic [2:0] m_awsize, m_awprot;
  logic [1:0] m_awburst;
  logic [3:0] m_awcache;
  logic [4:0] m_awuser;
  logic m_wvalid, m_wready, m_wlast;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic m_bvalid, m_bready;
  logic [1:0] m_bresp;
  logic busy, done, err;
  logic [CNT_W-1:0] beats_written;
  modport master (
    input cmd_valid, cmd_addr, cmd_beats, s_tvalid, s_tdata, s_tlast,
          m_awready, m_wready, m_bvalid, m_bresp,
    output cmd_ready, s_tready, m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
           m_awcache, m_awprot, m_awuser, m_wvalid, m_wdata, m_wstrb, m_wlast,
           m_bready, busy, done, err, beats_written
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_beats, s_tvalid, s_tdata, s_tlast,
           m_awready, m_wready, m_bvalid, m_bresp,
    input cmd_ready, s_tready, m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
          m_awcache, m_awprot, m_awuser, m_wvalid, m_wdata, m_wstrb, m_wlast,
          m_bready, busy, done, err, beats_written
  );
endinterface

// File: rtl/s2mm_axi_writer.sv
// s2mm_axi_writer: stream-to-memory AXI4 INCR-burst write engine, one burst outstanding at a time.
// S2MM_TLAST_TERM_EN: a tlast beat ends the command, padding the rest of its burst with wstrb=0.
module s2mm_axi_writer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BURST_LEN = 16,
  parameter int CNT_W = 24,
  parameter logic [3:0] AWCACHE = 4'hF,
  parameter logic [2:0] AWPROT = 3'h0,
  parameter logic [4:0] AWUSER = 5'h1
) (
  input logic clk_clk,
  input logic reset_reset,
  s2mm_axi_writer_if.master io
);
  localparam int SIZE = $clog2(DATA_W / 8);
  localparam int ALIGN_W = $clog2(BURST_LEN * DATA_W / 8);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d, bw_q, bw_d;
  logic [7:0] len_q, len_d;
  logic [8:0] beat_q, beat_d, real_q, real_d, burst, nb;
  logic err_q, err_d, term_q, term_d, tl, wfire, bad;
`ifdef S2MM_TLAST_TERM_EN
  assign tl = io.s_tlast;
`else
  assign tl = 1'b0;
`endif
  assign burst = (rem_q > CNT_W'(BURST_LEN)) ? 9'(BURST_LEN) : 9'(rem_q);
  // once terminated, only the strobed beats count towards progress
  assign nb = term_q ? real_q : 9'(len_q) + 9'd1;
  assign bad = (io.cmd_beats == '0) || (io.cmd_addr[ALIGN_W-1:0] != '0);
  assign io.cmd_ready = state_q == IDLE;
  assign io.busy = state_q != IDLE;
  assign io.done = state_q == FIN;
  assign io.err = err_q;
  assign io.beats_written = bw_q;
  assign io.m_awvalid = state_q == ADDR;
  assign io.m_awaddr = addr_q;
  assign io.m_awlen = 8'(burst - 9'd1);
  assign io.m_awsize = 3'(SIZE);
  assign io.m_awburst = 2'b01;
  assign io.m_awcache = AWCACHE;
  assign io.m_awprot = AWPROT;
  assign io.m_awuser = AWUSER;
  assign io.s_tready = (state_q == DATA) && !term_q && io.m_wready;
  assign io.m_wvalid = (state_q == DATA) && (term_q || io.s_tvalid);
  assign io.m_wdata = io.s_tdata;
  assign io.m_wstrb = term_q ? '0 : '1;
  assign io.m_wlast = (state_q == DATA) && (beat_q == 9'(len_q));
  assign io.m_bready = state_q == RESP;
  assign wfire = io.m_wvalid && io.m_wready;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    bw_d = bw_q;
    len_d = len_q;
    beat_d = beat_q;
    real_d = real_q;
    err_d = err_q;
    term_d = term_q;
    case (state_q)
      IDLE: if (io.cmd_valid) begin
        addr_d = io.cmd_addr;
        rem_d = io.cmd_beats;
        bw_d = '0;
        err_d = bad;
        state_d = bad ? FIN : ADDR;
      end
      ADDR: if (io.m_awready) begin
        len_d = io.m_awlen;
        beat_d = '0;
        term_d = 1'b0;
        state_d = DATA;
      end
      DATA: if (wfire) begin
        beat_d = beat_q + 9'd1;
        real_d = (tl && !term_q) ? beat_q + 9'd1 : real_q;
        term_d = term_q || tl;
        state_d = io.m_wlast ? RESP : DATA;
      end
      RESP: if (io.m_bvalid) begin
        err_d = err_q || (io.m_bresp != 2'b00);
        bw_d = bw_q + CNT_W'(nb);
        rem_d = rem_q - CNT_W'(nb);
        addr_d = addr_q + (ADDR_W'(nb) << SIZE);
        state_d = (rem_d != '0 && !err_d && !term_q) ? ADDR : FIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      bw_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      real_q <= '0;
      err_q <= 1'b0;
      term_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      bw_q <= bw_d;
      len_q <= len_d;
      beat_q <= beat_d;
      real_q <= real_d;
      err_q <= err_d;
      term_q <= term_d;
    end
  end
endmodule

// File: tb/tb_s2mm_axi_writer.sv
// tb_s2mm_axi_writer: randomized bench; expected bursts and data come from a burst-splitting model
`timescale 1ns/1ps
module tb_s2mm_axi_writer;
  localparam int ADDR_W = 32, DATA_W = 64, BURST_LEN = 16, CNT_W = 24;
  localparam int BB = BURST_LEN * DATA_W / 8;
  logic clk_clk = 1'b0, reset_reset = 1'b1;
  always #5 clk_clk = ~clk_clk;
  s2mm_axi_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  s2mm_axi_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .io(bus)
  );
  int n_tests = 0, n_fail = 0;
  bit stall = 0, outstanding = 0, aw_hold = 0;
  int err_burst = -1, bidx = 0, b_pend = 0, done_cnt = 0, aw_unstable = 0, aw_overlap = 0;
  logic [ADDR_W-1:0] hold_a;
  logic [7:0] hold_l;
  logic [DATA_W-1:0] sq_d[$], sent[$], w_d[$];
  bit sq_l[$], w_l[$];
  logic [DATA_W/8-1:0] w_s[$];
  logic [ADDR_W-1:0] aw_a[$], exp_a[$];
  logic [7:0] aw_l[$], exp_l[$];
  int exp_bw;
  bit exp_err;

  // environment: stream source, AW/W/B responders and bus monitor
  initial begin
    bit hs_s, hs_b;
    logic [DATA_W-1:0] tmp;
    bit tmpl;
    bus.s_tvalid = 0; bus.s_tdata = '0; bus.s_tlast = 0;
    bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 2'b00;
    forever begin
      hs_s = 0; hs_b = 0;
      @(negedge clk_clk);
      if (!reset_reset) begin
        hs_s = bus.s_tvalid && bus.s_tready;
        hs_b = bus.m_bvalid && bus.m_bready;
        if (bus.m_awvalid) begin
          if (aw_hold && (bus.m_awaddr !== hold_a || bus.m_awlen !== hold_l)) aw_unstable++;
          aw_hold = !bus.m_awready; hold_a = bus.m_awaddr; hold_l = bus.m_awlen;
          if (bus.m_awready) begin
            aw_a.push_back(bus.m_awaddr); aw_l.push_back(bus.m_awlen);
            if (outstanding) aw_overlap++;
            outstanding = 1;
          end
        end
        if (bus.m_wvalid && bus.m_wready) begin
          w_d.push_back(bus.m_wdata); w_s.push_back(bus.m_wstrb); w_l.push_back(bus.m_wlast);
          if (bus.m_wlast) b_pend++;
        end
        if (hs_b) outstanding = 0;
        if (bus.done) done_cnt++;
      end
      @(posedge clk_clk); #1;
      if (reset_reset) begin
        sq_d.delete(); sq_l.delete(); b_pend = 0; outstanding = 0; aw_hold = 0;
        bus.s_tvalid = 0; bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
      end else begin
        if (hs_s && sq_d.size() > 0) begin tmp = sq_d.pop_front(); tmpl = sq_l.pop_front(); end
        if (!bus.s_tvalid || hs_s) begin
          bus.s_tvalid = sq_d.size() > 0 && (!stall || $urandom_range(3) != 0);
          bus.s_tdata = bus.s_tvalid ? sq_d[0] : {$urandom, $urandom};
          bus.s_tlast = bus.s_tvalid ? sq_l[0] : 1'b0;
        end
        bus.m_awready = !stall || $urandom_range(2) == 0;
        bus.m_wready = !stall || $urandom_range(3) != 0;
        if (hs_b) begin
          bus.m_bvalid = 0; b_pend--; bidx++;
        end else if (!bus.m_bvalid && b_pend > 0 && (!stall || $urandom_range(2) == 0)) begin
          bus.m_bvalid = 1;
          bus.m_bresp = (bidx == err_burst) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // reference: split the command into aligned bursts, stop after an erroring response
  task automatic model(input logic [ADDR_W-1:0] a, input int beats, input int errb);
    int r, n, i;
    logic [ADDR_W-1:0] cur;
    r = beats; i = 0; cur = a;
    exp_a.delete(); exp_l.delete(); exp_bw = 0;
    exp_err = beats == 0 || (a % BB) != 0;
    while (!exp_err && r > 0) begin
      n = r < BURST_LEN ? r : BURST_LEN;
      exp_a.push_back(cur); exp_l.push_back(8'(n - 1));
      exp_bw += n; r -= n; cur += ADDR_W'(n * DATA_W / 8);
      exp_err = i == errb; i++;
    end
  endtask

  task automatic issue_cmd(input logic [ADDR_W-1:0] a, input int beats, input int errb, input int ndata);
    logic [DATA_W-1:0] d;
    @(posedge clk_clk); #2;
    aw_a.delete(); aw_l.delete(); w_d.delete(); w_s.delete(); w_l.delete(); sent.delete();
    done_cnt = 0; bidx = 0; err_burst = errb; aw_unstable = 0; aw_overlap = 0;
    for (int i = 0; i < ndata; i++) begin
      d = {$urandom, $urandom};
      sent.push_back(d); sq_d.push_back(d); sq_l.push_back(i == ndata - 1);
    end
    bus.cmd_addr = a; bus.cmd_beats = CNT_W'(beats); bus.cmd_valid = 1;
    @(posedge clk_clk); #2;
    bus.cmd_valid = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cyc);
    ok = 0; cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk_clk); cyc++; ok = bus.done;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_clk);
    n_tests++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.s_tready} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000000", {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.s_tready});
    end
    n_tests++;
    if (bus.beats_written !== '0) begin n_fail++; $display("FAIL reset_bw: got %0d want 0", bus.beats_written); end
    @(posedge clk_clk); #2;
    reset_reset = 0;
  endtask

  task automatic test_transfer(input string name, input logic [ADDR_W-1:0] a, input int beats, input int errb, input bit st);
    bit ok, el;
    int cyc, k, j;
    stall = st;
    model(a, beats, errb);
    issue_cmd(a, beats, errb, exp_bw);
    wait_done(30 * beats + 60, ok, cyc);
    repeat (3) @(negedge clk_clk);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_done: no done within %0d cycles", name, cyc); end
    if (exp_a.size() == 0) begin
      n_tests++;
      if (cyc > 2) begin n_fail++; $display("FAIL %s_latency: done after %0d cycles want <=2", name, cyc); end
    end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d want 1", name, done_cnt); end
    n_tests++;
    if (bus.err !== exp_err) begin n_fail++; $display("FAIL %s_err: got %b want %b", name, bus.err, exp_err); end
    n_tests++;
    if (bus.beats_written !== CNT_W'(exp_bw)) begin n_fail++; $display("FAIL %s_bw: got %0d want %0d", name, bus.beats_written, exp_bw); end
    n_tests++;
    if ({bus.busy, bus.cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL %s_idle: busy/ready %b want 01", name, {bus.busy, bus.cmd_ready}); end
    n_tests++;
    if (aw_a.size() != exp_a.size()) begin n_fail++; $display("FAIL %s_aw_cnt: got %0d want %0d", name, aw_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < aw_a.size(); i++) begin
      n_tests++;
      if (aw_a[i] !== exp_a[i] || aw_l[i] !== exp_l[i]) begin
        n_fail++; $display("FAIL %s_aw%0d: got %h/%0d want %h/%0d", name, i, aw_a[i], aw_l[i], exp_a[i], exp_l[i]);
      end
      n_tests++;
      if (int'(aw_a[i][11:0]) + (int'(aw_l[i]) + 1) * (DATA_W / 8) > 4096) begin
        n_fail++; $display("FAIL %s_4k%0d: burst at %h len %0d crosses 4KB", name, i, aw_a[i], aw_l[i]);
      end
    end
    n_tests++;
    if (w_d.size() != exp_bw) begin n_fail++; $display("FAIL %s_w_cnt: got %0d want %0d", name, w_d.size(), exp_bw); end
    k = 0; j = 0;
    for (int i = 0; i < w_d.size() && i < sent.size() && k < exp_l.size(); i++) begin
      el = j == int'(exp_l[k]);
      n_tests++;
      if (w_d[i] !== sent[i] || w_s[i] !== '1 || w_l[i] !== el) begin
        n_fail++; $display("FAIL %s_w%0d: got %h/%h/%b want %h/ff/%b", name, i, w_d[i], w_s[i], w_l[i], sent[i], el);
      end
      if (el) begin k++; j = 0; end else j++;
    end
    n_tests++;
    if (aw_unstable != 0 || aw_overlap != 0) begin
      n_fail++; $display("FAIL %s_aw_rules: unstable=%0d overlap=%0d want 0/0", name, aw_unstable, aw_overlap);
    end
  endtask

  task automatic test_reset_mid;
    int c;
    stall = 0;
    issue_cmd(32'h2000, 40, -1, 40);
    c = 0;
    while (w_d.size() < 5 && c < 200) begin @(negedge clk_clk); c++; end
    n_tests++;
    if (w_d.size() < 5) begin n_fail++; $display("FAIL rst_mid_reach: only %0d beats seen want 5", w_d.size()); end
    #2 reset_reset = 1;
    #1;
    n_tests++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.s_tready} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL rst_mid_ctrl: got %b want 10000000", {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.s_tready});
    end
    n_tests++;
    if (bus.beats_written !== '0) begin n_fail++; $display("FAIL rst_mid_bw: got %0d want 0", bus.beats_written); end
    repeat (3) @(posedge clk_clk);
    #2 reset_reset = 0;
    test_transfer("after_rst", 32'h3000, 20, -1, 0);
  endtask

`ifdef S2MM_TLAST_TERM_EN
  task automatic test_tlast_term;
    bit ok;
    int cyc;
    stall = 1;
    issue_cmd(32'h6000, 32, -1, 20);
    wait_done(1200, ok, cyc);
    repeat (3) @(negedge clk_clk);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL tlast_done: no done within %0d cycles", cyc); end
    n_tests++;
    if (bus.beats_written !== CNT_W'(20)) begin n_fail++; $display("FAIL tlast_bw: got %0d want 20", bus.beats_written); end
    n_tests++;
    if (aw_a.size() != 2 || w_d.size() != 32) begin n_fail++; $display("FAIL tlast_cnt: aw=%0d w=%0d want 2/32", aw_a.size(), w_d.size()); end
    for (int i = 0; i < w_d.size() && i < 32; i++) begin
      n_tests++;
      if (w_s[i] !== (i < 20 ? 8'hff : 8'h00) || (i < 20 && w_d[i] !== sent[i])) begin
        n_fail++; $display("FAIL tlast_w%0d: got %h/%h", i, w_d[i], w_s[i]);
      end
    end
  endtask
`endif

  initial begin
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_beats = '0;
    test_reset();
    test_transfer("basic", 32'h1000, 40, -1, 0);
    for (int i = 0; i < 6; i++)
      test_transfer("stall", ADDR_W'($urandom_range(0, 1023) * BB), int'($urandom_range(1, 60)), -1, 1);
    test_transfer("exact_burst", 32'h5000, 16, -1, 1);
    test_transfer("bresp_err", 32'h4000, 48, 1, 1);
    test_transfer("unaligned", 32'h1004, 8, -1, 0);
    test_transfer("zero_beats", 32'h1000, 0, -1, 0);
    test_reset_mid();
`ifdef S2MM_TLAST_TERM_EN
    test_tlast_term();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
